hms_time_counter: RTL and testbench

- Time-of-day counter that produces the seconds, minutes and hours values that the digital-clock datapath compares against its rollover limits.
- Advances on a one-cycle tick enable and wraps seconds and minutes at 60 and hours at 24.
- Has a user set mode that loads individual fields, with a range check on each load.
- Sits between the 1 Hz tick divider and the display/alarm logic.

---
 rtl/hms_time_counter.sv | 120 ++++++++++++
 tb/tb_hms_time_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hms_time_counter.sv
// rtl/hms_time_counter.sv - time-of-day counter with RUN/SET modes and range-checked field loads
module hms_time_counter #(
  parameter int N       = 8,
  parameter int SEC_MAX = 60,
  parameter int MIN_MAX = 60,
  parameter int HR_MAX  = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         set_en,
  input  logic [1:0]   set_sel,
  input  logic [N-1:0] set_val,
  input  logic         set_stb,
  output logic [N-1:0] sec,
  output logic [N-1:0] min,
  output logic [N-1:0] hr,
  output logic         sec_wrap,
  output logic         min_wrap,
  output logic         day_wrap,
  output logic         set_err,
  output logic         mode
);

  typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

  localparam logic [N-1:0] SEC_LAST = N'(SEC_MAX - 1);
  localparam logic [N-1:0] MIN_LAST = N'(MIN_MAX - 1);
  localparam logic [N-1:0] HR_LAST  = N'(HR_MAX - 1);
  // One extra bit so the limits are representable even when N is exactly wide enough for MAX-1
  localparam logic [N:0]   SEC_LIM  = (N+1)'(SEC_MAX);
  localparam logic [N:0]   MIN_LIM  = (N+1)'(MIN_MAX);
  localparam logic [N:0]   HR_LIM   = (N+1)'(HR_MAX);

  state_t       state_q, state_d;
  logic [N-1:0] sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic         sec_wrap_q, sec_wrap_d, min_wrap_q, min_wrap_d;
  logic         day_wrap_q, day_wrap_d, set_err_q, set_err_d;

  always_comb begin
    state_d    = state_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hr_d       = hr_q;
    sec_wrap_d = 1'b0;
    min_wrap_d = 1'b0;
    day_wrap_d = 1'b0;
    set_err_d  = 1'b0;
    if (state_q == RUN) begin
      // Entering SET wins over a coincident tick
      if (set_en) begin
        state_d = SET;
        sec_d   = '0;
      end else if (tick) begin
        if (sec_q == SEC_LAST) begin
          sec_d      = '0;
          sec_wrap_d = 1'b1;
          if (min_q == MIN_LAST) begin
            min_d      = '0;
            min_wrap_d = 1'b1;
            if (hr_q == HR_LAST) begin
              hr_d       = '0;
              day_wrap_d = 1'b1;
            end else begin
              hr_d = hr_q + N'(1);
            end
          end else begin
            min_d = min_q + N'(1);
          end
        end else begin
          sec_d = sec_q + N'(1);
        end
      end
    end else begin
      if (!set_en) begin
        state_d = RUN;
      end
      if (set_stb) begin
        case (set_sel)
          2'b00:   if ({1'b0, set_val} < SEC_LIM) sec_d = set_val; else set_err_d = 1'b1;
          2'b01:   if ({1'b0, set_val} < MIN_LIM) min_d = set_val; else set_err_d = 1'b1;
          2'b10:   if ({1'b0, set_val} < HR_LIM)  hr_d  = set_val; else set_err_d = 1'b1;
          default: set_err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      sec_q      <= '0;
      min_q      <= '0;
      hr_q       <= '0;
      sec_wrap_q <= 1'b0;
      min_wrap_q <= 1'b0;
      day_wrap_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      sec_wrap_q <= sec_wrap_d;
      min_wrap_q <= min_wrap_d;
      day_wrap_q <= day_wrap_d;
      set_err_q  <= set_err_d;
    end
  end

  assign sec      = sec_q;
  assign min      = min_q;
  assign hr       = hr_q;
  assign sec_wrap = sec_wrap_q;
  assign min_wrap = min_wrap_q;
  assign day_wrap = day_wrap_q;
  assign set_err  = set_err_q;
  assign mode     = (state_q == SET);

endmodule

// File: tb/tb_hms_time_counter.sv
// tb/tb_hms_time_counter.sv - self-checking bench for hms_time_counter
module tb_hms_time_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, set_en, set_stb;
  logic [1:0] set_sel;
  logic [7:0] set_val;
  logic [7:0] sec, min, hr;
  logic       sec_wrap, min_wrap, day_wrap, set_err, mode;

  int total = 0;
  int bad   = 0;

  // Reference state: time of day as a single count of seconds since midnight
  int m_t;
  bit m_set, m_sw, m_mw, m_dw, m_err;

  hms_time_counter dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .set_en(set_en),
    .set_sel(set_sel), .set_val(set_val), .set_stb(set_stb),
    .sec(sec), .min(min), .hr(hr),
    .sec_wrap(sec_wrap), .min_wrap(min_wrap), .day_wrap(day_wrap),
    .set_err(set_err), .mode(mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       tk, en, stb;
    int       sel, val;
    int       e_sec, e_min, e_hr, e_mode, e_err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_set = 0; m_sw = 0; m_mw = 0; m_dw = 0; m_err = 0;
  endtask

  task automatic model_step(input bit tk, input bit en, input bit stb, input int sel, input int val);
    int s, m, h;
    m_sw = 0; m_mw = 0; m_dw = 0; m_err = 0;
    if (!m_set) begin
      if (en) begin
        m_set = 1;
        m_t   = m_t - (m_t % 60);
      end else if (tk) begin
        m_t  = (m_t + 1) % 86400;
        m_sw = (m_t % 60) == 0;
        m_mw = (m_t % 3600) == 0;
        m_dw = (m_t == 0);
      end
    end else begin
      if (stb) begin
        s = m_t % 60; m = (m_t / 60) % 60; h = m_t / 3600;
        if      (sel == 0 && val < 60) s = val;
        else if (sel == 1 && val < 60) m = val;
        else if (sel == 2 && val < 24) h = val;
        else m_err = 1;
        m_t = h * 3600 + m * 60 + s;
      end
      if (!en) m_set = 0;
    end
  endtask

  task automatic check_model();
    chk("sec", sec, m_t % 60);
    chk("min", min, (m_t / 60) % 60);
    chk("hr", hr, m_t / 3600);
    chk("mode", mode, m_set);
    chk("sec_wrap", sec_wrap, m_sw);
    chk("min_wrap", min_wrap, m_mw);
    chk("day_wrap", day_wrap, m_dw);
    chk("set_err", set_err, m_err);
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare against the model
  task automatic apply(input bit tk, input bit en, input bit stb, input int sel, input int val);
    tick = tk; set_en = en; set_stb = stb;
    set_sel = 2'(sel); set_val = 8'(val);
    @(posedge clk);
    #1;
    model_step(tk, en, stb, sel, val);
    check_model();
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{0,1,0,0,0,   0, 1, 0,1,0},
      '{0,1,1,1,45,  0,45, 0,1,0},
      '{1,1,0,0,0,   0,45, 0,1,0},
      '{0,1,1,2,24,  0,45, 0,1,1},
      '{0,1,1,3,3,   0,45, 0,1,1},
      '{0,1,1,0,60,  0,45, 0,1,1},
      '{0,1,1,0,200, 0,45, 0,1,1},
      '{0,1,1,2,23,  0,45,23,1,0},
      '{0,1,1,1,59,  0,59,23,1,0},
      '{0,1,1,0,57, 57,59,23,1,0},
      '{1,0,0,0,0,  57,59,23,0,0},
      '{0,0,1,0,10, 57,59,23,0,0},
      '{1,0,0,0,0,  58,59,23,0,0},
      '{1,0,0,0,0,  59,59,23,0,0}
    };

    rst_n = 1'b0; tick = 0; set_en = 0; set_stb = 0; set_sel = 0; set_val = 0;
    model_reset();
    #12;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    // 59 ticks then the 60th wraps seconds into minutes
    for (int i = 0; i < 59; i++) apply(1, 0, 0, 0, 0);
    chk("sec_at_59", sec, 59);
    chk("min_at_59", min, 0);
    chk("no_wrap_at_59", sec_wrap, 0);
    apply(1, 0, 0, 0, 0);
    chk("sec_after_60", sec, 0);
    chk("min_after_60", min, 1);
    chk("sec_wrap_60", sec_wrap, 1);
    apply(0, 0, 0, 0, 0);
    chk("sec_wrap_drop", sec_wrap, 0);

    // Set mode sequence, range checks, RUN ignores strobes
    foreach (vecs[i]) begin
      apply(vecs[i].tk, vecs[i].en, vecs[i].stb, vecs[i].sel, vecs[i].val);
      chk($sformatf("vec%0d_sec", i), sec, vecs[i].e_sec);
      chk($sformatf("vec%0d_min", i), min, vecs[i].e_min);
      chk($sformatf("vec%0d_hr", i), hr, vecs[i].e_hr);
      chk($sformatf("vec%0d_mode", i), mode, vecs[i].e_mode);
      chk($sformatf("vec%0d_err", i), set_err, vecs[i].e_err);
    end

    // 23:59:59 + tick resolves the whole carry chain at once
    apply(1, 0, 0, 0, 0);
    chk("day_sec", sec, 0);
    chk("day_min", min, 0);
    chk("day_hr", hr, 0);
    chk("day_sw", sec_wrap, 1);
    chk("day_mw", min_wrap, 1);
    chk("day_dw", day_wrap, 1);
    apply(0, 0, 0, 0, 0);
    chk("day_pulses_drop", {sec_wrap, min_wrap, day_wrap}, 0);

    // Tick coincident with set_en rise: enters SET, seconds clear
    for (int i = 0; i < 5; i++) apply(1, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 0);
    chk("coinc_sec", sec, 0);
    chk("coinc_mode", mode, 1);
    apply(1, 0, 0, 0, 0);
    chk("exit_tick_ignored", sec, 0);
    apply(1, 0, 0, 0, 0);
    chk("resume_tick", sec, 1);

    // Asynchronous reset while in SET at 12:30:15
    apply(0, 1, 0, 0, 0);
    apply(0, 1, 1, 2, 12);
    apply(0, 1, 1, 1, 30);
    apply(0, 1, 1, 0, 15);
    chk("pre_rst_hr", hr, 12);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_sec", sec, 0);
    chk("arst_min", min, 0);
    chk("arst_hr", hr, 0);
    chk("arst_mode", mode, 0);
    model_reset();
    tick = 0; set_en = 0; set_stb = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      bit en_r;
      int v;
      en_r = ($urandom_range(0, 15) == 0) ? ~set_en : set_en;
      v    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 65);
      apply($urandom_range(0, 3) != 0, en_r, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
